// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the frame configuration loader: FSM state encoding,
// header sync byte and header field positions.
package fabric_cfg_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_DATA   = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } cfg_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hFA;

   // Header layout: [31:24] sync, [23:16] column, [15:8] frame, [7:0] unused
   localparam int HDR_FIELD_W  = 8;
   localparam int HDR_SYNC_LSB = 24;
   localparam int HDR_COL_LSB  = 16;
   localparam int HDR_FRM_LSB  = 8;

   function automatic logic [HDR_FIELD_W-1:0] hdr_field(input logic [31:0] word,
                                                        input int          lsb);
      return word[lsb +: HDR_FIELD_W];
   endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Turns a flat latch-enable index into a one-hot strobe vector. An index past
// the end of the vector produces no strobe, so at most one bit is ever set.
module frame_strobe_decoder #(
   parameter int WIDTH = 160,
   parameter int IDX_W = 8
) (
   input  logic [IDX_W-1:0] index,
   input  logic             enable,
   output logic [WIDTH-1:0] onehot
);

   // Single-bit decode of the index when enabled
   always_comb begin
      onehot = '0;
      if (enable && (32'(index) < 32'(WIDTH))) begin
         onehot[index] = 1'b1;
      end
   end

endmodule

// File: rtl/frame_config_loader.sv
// Streams configuration words into fabric frame latches: a header selects the
// column/frame, NUM_ROWS data words fill FrameData, then a single latch-enable
// strobe commits the frame.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_HUNT   | waiting for a header word; non-sync words flag err_sync
// ST_DATA   | collecting NUM_ROWS data words into FrameData
// ST_STROBE | one-hot latch enable asserted for STROBE_CYCLES cycles
// ST_HOLD   | one quiet cycle with strobe low and data stable before HUNT
module frame_config_loader
   import fabric_cfg_pkg::*;
#(
   parameter int NUM_ROWS       = 4,
   parameter int NUM_COLUMNS    = 8,
   parameter int FRAMES_PER_COL = 20,
   parameter int STROBE_CYCLES  = 2
) (
   input  logic                                  CLK,
   input  logic                                  resetn,
   input  logic [31:0]                           cfg_word,
   input  logic                                  cfg_valid,
   output logic                                  cfg_ready,
   output logic [NUM_ROWS*32-1:0]                FrameData,
   output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0] FrameStrobe,
   output logic                                  busy,
   output logic                                  err_sync,
   output logic                                  err_addr,
   output logic [15:0]                           frames_done
);

   localparam int NUM_STROBES = NUM_COLUMNS * FRAMES_PER_COL;
   localparam int IDX_W       = (NUM_STROBES > 1) ? $clog2(NUM_STROBES) : 1;
   localparam int ROW_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int SC_W        = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

   cfg_state_t              state;
   logic [ROW_W-1:0]        row_cnt;
   logic [SC_W-1:0]         strobe_cnt;
   logic [IDX_W-1:0]        strobe_idx;
   logic                    drop;

   logic                    accept;
   logic                    last_row;
   logic [7:0]              hdr_sync;
   logic [7:0]              hdr_col;
   logic [7:0]              hdr_frm;
   logic                    addr_bad;
   logic [IDX_W-1:0]        hdr_idx;
   logic                    strobe_next_en;
   logic [NUM_STROBES-1:0]  strobe_onehot;

   assign accept   = cfg_valid && cfg_ready;
   assign last_row = (row_cnt == ROW_W'(NUM_ROWS - 1));
   assign hdr_sync = hdr_field(cfg_word, HDR_SYNC_LSB);
   assign hdr_col  = hdr_field(cfg_word, HDR_COL_LSB);
   assign hdr_frm  = hdr_field(cfg_word, HDR_FRM_LSB);
   assign addr_bad = ({24'd0, hdr_col} >= 32'(NUM_COLUMNS)) ||
                     ({24'd0, hdr_frm} >= 32'(FRAMES_PER_COL));
   assign hdr_idx  = IDX_W'({24'd0, hdr_col} * 32'(FRAMES_PER_COL) + {24'd0, hdr_frm});

   // Sequencing FSM: header decode, row capture, strobe timing and status outputs
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_HUNT;
         cfg_ready   <= 1'b0;
         busy        <= 1'b0;
         err_sync    <= 1'b0;
         err_addr    <= 1'b0;
         frames_done <= '0;
         row_cnt     <= '0;
         drop        <= 1'b0;
         strobe_cnt  <= '0;
         strobe_idx  <= '0;
         FrameData   <= '0;
      end else begin
         err_sync <= 1'b0;
         err_addr <= 1'b0;
         case (state)
            ST_HUNT: begin
               cfg_ready <= 1'b1;
               busy      <= 1'b0;
               if (accept) begin
                  if (hdr_sync != SYNC_BYTE) begin
                     err_sync <= 1'b1;
                  end else begin
                     state      <= ST_DATA;
                     busy       <= 1'b1;
                     row_cnt    <= '0;
                     drop       <= addr_bad;
                     err_addr   <= addr_bad;
                     strobe_idx <= addr_bad ? '0 : hdr_idx;
                  end
               end
            end

            ST_DATA: begin
               if (accept) begin
                  for (int k = 0; k < NUM_ROWS; k++) begin
                     if (row_cnt == ROW_W'(k)) begin
                        FrameData[32*k +: 32] <= cfg_word;
                     end
                  end
                  if (last_row) begin
                     row_cnt <= '0;
                     if (drop) begin
                        // Out-of-range target: data is absorbed, nothing is latched
                        state <= ST_HUNT;
                        busy  <= 1'b0;
                        drop  <= 1'b0;
                     end else begin
                        state      <= ST_STROBE;
                        cfg_ready  <= 1'b0;
                        strobe_cnt <= SC_W'(STROBE_CYCLES - 1);
                     end
                  end else begin
                     row_cnt <= row_cnt + ROW_W'(1);
                  end
               end
            end

            ST_STROBE: begin
               cfg_ready <= 1'b0;
               if (strobe_cnt == '0) begin
                  state       <= ST_HOLD;
                  frames_done <= frames_done + 16'd1;
               end else begin
                  strobe_cnt <= strobe_cnt - SC_W'(1);
               end
            end

            ST_HOLD: begin
               state     <= ST_HUNT;
               cfg_ready <= 1'b1;
               busy      <= 1'b0;
            end

            default: begin
               state     <= ST_HUNT;
               cfg_ready <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Strobe is wanted next cycle when a good frame completes or the pulse is still running
   always_comb begin
      strobe_next_en = 1'b0;
      if ((state == ST_DATA) && accept && last_row && !drop) begin
         strobe_next_en = 1'b1;
      end else if ((state == ST_STROBE) && (strobe_cnt != '0)) begin
         strobe_next_en = 1'b1;
      end
   end

   frame_strobe_decoder #(
      .WIDTH (NUM_STROBES),
      .IDX_W (IDX_W)
   ) u_strobe_dec (
      .index  (strobe_idx),
      .enable (strobe_next_en),
      .onehot (strobe_onehot)
   );

   // Latch enables are driven from a register so the fabric never sees decode glitches
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         FrameStrobe <= '0;
      end else begin
         FrameStrobe <= strobe_onehot;
      end
   end

endmodule

// File: tb/tb_frame_config_loader.sv
// Self-checking bench for frame_config_loader: a transaction-level model of the
// loader is compared against the DUT every cycle, plus directed literal checks.
module tb_frame_config_loader;

   localparam int NR  = 4;
   localparam int NC  = 8;
   localparam int FPC = 20;
   localparam int SC  = 2;
   localparam int NS  = NC * FPC;

   logic                CLK = 1'b0;
   logic                resetn = 1'b0;
   logic [31:0]         cfg_word = '0;
   logic                cfg_valid = 1'b0;
   logic                cfg_ready;
   logic [NR*32-1:0]    FrameData;
   logic [NS-1:0]       FrameStrobe;
   logic                busy;
   logic                err_sync;
   logic                err_addr;
   logic [15:0]         frames_done;

   always #5 CLK = ~CLK;

   frame_config_loader #(
      .NUM_ROWS       (NR),
      .NUM_COLUMNS    (NC),
      .FRAMES_PER_COL (FPC),
      .STROBE_CYCLES  (SC)
   ) dut (
      .CLK         (CLK),
      .resetn      (resetn),
      .cfg_word    (cfg_word),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .FrameData   (FrameData),
      .FrameStrobe (FrameStrobe),
      .busy        (busy),
      .err_sync    (err_sync),
      .err_addr    (err_addr),
      .frames_done (frames_done)
   );

   int checks = 0;
   int errors = 0;

   // Model: frame-level view. m_post counts cycles since the last data word of a
   // good frame (1..SC strobe, SC+1 quiet), 0 when the loader takes words.
   bit          m_boot;
   int          m_post;
   bit          m_in_frame;
   int          m_nrows;
   bit          m_drop;
   int          m_idx;
   logic [31:0] m_rows [NR];
   logic [15:0] m_frames;
   bit          m_es;
   bit          m_ea;

   int  hits [NS];
   int  strobe_total = 0;
   int  es_count = 0;
   int  ea_count = 0;
   int  ready_low = 0;
   bit  last_ready = 1'b0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_boot = 1'b1; m_post = 0; m_in_frame = 1'b0; m_nrows = 0; m_drop = 1'b0;
      m_idx = 0; m_frames = '0; m_es = 1'b0; m_ea = 1'b0;
      for (int k = 0; k < NR; k++) m_rows[k] = '0;
   endtask

   function automatic bit exp_ready();
      return !m_boot && (m_post == 0);
   endfunction

   function automatic logic [NS-1:0] exp_strobe();
      logic [NS-1:0] s = '0;
      if (m_post >= 1 && m_post <= SC) s[m_idx] = 1'b1;
      return s;
   endfunction

   function automatic logic [NR*32-1:0] exp_data();
      logic [NR*32-1:0] d = '0;
      for (int k = 0; k < NR; k++) d[32*k +: 32] = m_rows[k];
      return d;
   endfunction

   task automatic model_step();
      bit acc;
      logic [7:0] col, frm;
      acc = cfg_valid && exp_ready();
      m_es = 1'b0;
      m_ea = 1'b0;
      if (m_boot) m_boot = 1'b0;
      if (m_post != 0) begin
         if (m_post == SC + 1) m_post = 0;
         else begin
            m_post++;
            if (m_post == SC + 1) m_frames++;
         end
      end else if (acc) begin
         if (!m_in_frame) begin
            if (cfg_word[31:24] != 8'hFA) m_es = 1'b1;
            else begin
               col = cfg_word[23:16];
               frm = cfg_word[15:8];
               m_in_frame = 1'b1;
               m_nrows = 0;
               m_drop = (int'(col) >= NC) || (int'(frm) >= FPC);
               m_ea = m_drop;
               m_idx = int'(col) * FPC + int'(frm);
            end
         end else begin
            m_rows[m_nrows] = cfg_word;
            m_nrows++;
            if (m_nrows == NR) begin
               m_in_frame = 1'b0;
               if (!m_drop) m_post = 1;
            end
         end
      end
   endtask

   // One clock: compare at the falling edge, advance the model, return after the rising edge.
   task automatic tick();
      @(negedge CLK);
      if (!resetn) model_reset();
      chk("cfg_ready",   256'(cfg_ready),   256'(exp_ready()));
      chk("busy",        256'(busy),        256'(m_in_frame || (m_post != 0)));
      chk("err_sync",    256'(err_sync),    256'(m_es));
      chk("err_addr",    256'(err_addr),    256'(m_ea));
      chk("frames_done", 256'(frames_done), 256'(m_frames));
      chk("FrameData",   256'(FrameData),   256'(exp_data()));
      chk("FrameStrobe", 256'(FrameStrobe), 256'(exp_strobe()));
      last_ready = cfg_ready;
      if (resetn) begin
         for (int i = 0; i < NS; i++) begin
            if (FrameStrobe[i]) begin
               hits[i]++;
               strobe_total++;
            end
         end
         if (err_sync) es_count++;
         if (err_addr) ea_count++;
         if (!cfg_ready) ready_low++;
         model_step();
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      cfg_valid = 1'b0;
      cfg_word  = $urandom;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [31:0] w);
      int n = 0;
      cfg_word  = w;
      cfg_valid = 1'b1;
      do begin
         tick();
         n++;
      end while (!last_ready && n < 40);
      chk("send_accept", 256'(last_ready), 256'(1));
      cfg_valid = 1'b0;
   endtask

   // Assert reset mid-cycle, confirm the asynchronous clear, release after the next edge.
   task automatic apply_reset();
      #2;
      resetn = 1'b0;
      #1;
      chk("rst_FrameData",   256'(FrameData),   256'(0));
      chk("rst_FrameStrobe", 256'(FrameStrobe), 256'(0));
      chk("rst_cfg_ready",   256'(cfg_ready),   256'(0));
      chk("rst_busy",        256'(busy),        256'(0));
      chk("rst_frames_done", 256'(frames_done), 256'(0));
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int h0, t0, e0, r0;
      logic [7:0] col, frm, gb;

      model_reset();
      @(posedge CLK);
      #1;
      apply_reset();

      // Basic frame to column 2 frame 5 -> strobe index 45
      h0 = hits[45]; t0 = strobe_total;
      send(32'hFA_02_05_00);
      send(32'h11111111); send(32'h22222222); send(32'h33333333); send(32'h44444444);
      idle(SC + 3);
      chk("basic_data", 256'(FrameData), 256'(128'h44444444_33333333_22222222_11111111));
      chk("basic_bit45_cycles", 256'(hits[45] - h0), 256'(2));
      chk("basic_strobe_total", 256'(strobe_total - t0), 256'(2));
      chk("basic_frames_done", 256'(frames_done), 256'(1));

      // Non-sync word in HUNT
      e0 = es_count; t0 = strobe_total;
      send(32'h12_00_00_00);
      idle(3);
      chk("sync_err_pulses", 256'(es_count - e0), 256'(1));
      chk("sync_busy", 256'(busy), 256'(0));
      chk("sync_no_strobe", 256'(strobe_total - t0), 256'(0));

      // Column out of range: data absorbed, nothing latched
      e0 = ea_count; t0 = strobe_total;
      send(32'hFA_08_00_00);
      send(32'hAAAA0001); send(32'hAAAA0002); send(32'hAAAA0003); send(32'hAAAA0004);
      idle(SC + 3);
      chk("addr_err_pulses", 256'(ea_count - e0), 256'(1));
      chk("addr_no_strobe", 256'(strobe_total - t0), 256'(0));
      chk("addr_frames_done", 256'(frames_done), 256'(1));
      chk("addr_busy", 256'(busy), 256'(0));

      // cfg_valid toggling every cycle during DATA, column 0 frame 19
      h0 = hits[19]; t0 = strobe_total;
      send(32'hFA_00_13_00);
      idle(1); send(32'h0BAD0001);
      idle(1); send(32'h0BAD0002);
      idle(1); send(32'h0BAD0003);
      idle(1); send(32'h0BAD0004);
      idle(SC + 3);
      chk("toggle_data", 256'(FrameData), 256'(128'h0BAD0004_0BAD0003_0BAD0002_0BAD0001));
      chk("toggle_bit19_cycles", 256'(hits[19] - h0), 256'(2));
      chk("toggle_strobe_total", 256'(strobe_total - t0), 256'(2));
      chk("toggle_frames_done", 256'(frames_done), 256'(2));

      // Reset while strobing: strobe dropped, frame not counted
      send(32'hFA_03_01_00);
      send(32'h1); send(32'h2); send(32'h3); send(32'h4);
      chk("midstrobe_active", 256'(FrameStrobe), 256'(160'd1 << 61));
      apply_reset();
      idle(2);
      chk("midstrobe_frames_done", 256'(frames_done), 256'(0));

      // Reset after the second data word, then a full frame to column 7 frame 0
      send(32'hFA_01_01_00);
      send(32'hDEAD0001); send(32'hDEAD0002);
      apply_reset();
      h0 = hits[140]; t0 = strobe_total;
      send(32'hFA_07_00_00);
      send(32'hC0DE0001); send(32'hC0DE0002); send(32'hC0DE0003); send(32'hC0DE0004);
      idle(SC + 3);
      chk("rstdata_data", 256'(FrameData), 256'(128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001));
      chk("rstdata_bit140_cycles", 256'(hits[140] - h0), 256'(2));
      chk("rstdata_strobe_total", 256'(strobe_total - t0), 256'(2));
      chk("rstdata_frames_done", 256'(frames_done), 256'(1));

      // Three back-to-back frames with cfg_valid held high
      r0 = ready_low;
      for (int f = 0; f < 3; f++) begin
         send({8'hFA, 8'(f + 4), 8'(f * 3), 8'h00});
         for (int k = 0; k < NR; k++) send({8'(f), 8'h5A, 8'h00, 8'(k)});
      end
      idle(SC + 3);
      chk("stream_ready_low", 256'(ready_low - r0), 256'(3 * (SC + 1)));
      chk("stream_frames_done", 256'(frames_done), 256'(4));
      chk("stream_data", 256'(FrameData), 256'(128'h025A0003_025A0002_025A0001_025A0000));

      // Randomized traffic against the model
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            do gb = 8'($urandom_range(0, 255)); while (gb == 8'hFA);
            send({gb, 24'($urandom)});
         end
         idle($urandom_range(0, 2));
         col = 8'($urandom_range(0, 9));
         frm = 8'($urandom_range(0, 21));
         send({8'hFA, col, frm, 8'($urandom)});
         for (int k = 0; k < NR; k++) begin
            idle($urandom_range(0, 2));
            if (f == 25 && k == 2) apply_reset();
            send($urandom);
         end
      end
      idle(SC + 3);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
